jtag_tap_ctrl: RTL

JTAG TAP controller that sequences the boundary-scan data-register block. It walks the 16-state IEEE 1149.1 TAP state machine from TMS and holds the 4-bit instruction register. It drives the DR capture/shift/update strobes and the one-hot instruction selects, and muxes the serial returns onto TDO. It sits between the chip's JTAG pins and the DR block (BSR, ID and user registers).

---
 rtl/jtag_tap_ctrl.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/jtag_tap_ctrl.sv
// IEEE 1149.1 TAP controller: 16-state FSM, 4-bit IR, DR strobes, one-hot selects and TDO mux.
// Define TAP_IDCODE_DEFAULT_EN to make IDCODE the reset/TLR instruction (BYPASS otherwise).
module jtag_tap_ctrl (
    input  logic       TCK,
    input  logic       TRST,
    input  logic       TMS,
    input  logic       TDI,
    input  logic       BSR_TDO,
    input  logic       ID_REG_TDO,
    input  logic       USER_REG_TDO,
    output logic       CAPTUREDR,
    output logic       SHIFTDR,
    output logic       UPDATEDR,
    output logic       BYPASS_SELECT,
    output logic       SAMPLE_SELECT,
    output logic       EXTEST_SELECT,
    output logic       INTEST_SELECT,
    output logic       RUNBIST_SELECT,
    output logic       CLAMP_SELECT,
    output logic       IDCODE_SELECT,
    output logic       USERCODE_SELECT,
    output logic       HIGHZ_SELECT,
    output logic [3:0] IR,
    output logic [3:0] TAP_STATE,
    output logic       TDO,
    output logic       TDO_EN
);

    localparam int IR_W = 4;

    typedef enum logic [3:0] {
        S_EX2DR   = 4'h0,
        S_EX1DR   = 4'h1,
        S_SHDR    = 4'h2,
        S_PAUSEDR = 4'h3,
        S_SELIR   = 4'h4,
        S_UPDDR   = 4'h5,
        S_CAPDR   = 4'h6,
        S_SELDR   = 4'h7,
        S_EX2IR   = 4'h8,
        S_EX1IR   = 4'h9,
        S_SHIR    = 4'hA,
        S_PAUSEIR = 4'hB,
        S_RTI     = 4'hC,
        S_UPDIR   = 4'hD,
        S_CAPIR   = 4'hE,
        S_TLR     = 4'hF
    } tap_state_t;

    localparam logic [IR_W-1:0] I_EXTEST   = 4'b0000;
    localparam logic [IR_W-1:0] I_SAMPLE   = 4'b0001;
    localparam logic [IR_W-1:0] I_INTEST   = 4'b0010;
    localparam logic [IR_W-1:0] I_RUNBIST  = 4'b0011;
    localparam logic [IR_W-1:0] I_CLAMP    = 4'b0100;
    localparam logic [IR_W-1:0] I_IDCODE   = 4'b0101;
    localparam logic [IR_W-1:0] I_USERCODE = 4'b0110;
    localparam logic [IR_W-1:0] I_HIGHZ    = 4'b0111;
    localparam logic [IR_W-1:0] I_BYPASS   = 4'b1111;

`ifdef TAP_IDCODE_DEFAULT_EN
    localparam logic [IR_W-1:0] DEFAULT_IR = I_IDCODE;
`else
    localparam logic [IR_W-1:0] DEFAULT_IR = I_BYPASS;
`endif

    // Bit positions inside the one-hot select vector.
    localparam int SEL_BYPASS   = 0;
    localparam int SEL_SAMPLE   = 1;
    localparam int SEL_EXTEST   = 2;
    localparam int SEL_INTEST   = 3;
    localparam int SEL_RUNBIST  = 4;
    localparam int SEL_CLAMP    = 5;
    localparam int SEL_IDCODE   = 6;
    localparam int SEL_USERCODE = 7;
    localparam int SEL_HIGHZ    = 8;

    tap_state_t      state;
    tap_state_t      next_state;
    logic [IR_W-1:0] ir_sr;
    logic [IR_W-1:0] ir_reg;
    logic [8:0]      sel;
    logic            bypass_bit;
    logic            tdo_int;

    function automatic logic [8:0] decode_ir(input logic [IR_W-1:0] code);
        logic [8:0] onehot;
        onehot = '0;
        case (code)
            I_EXTEST:   onehot[SEL_EXTEST]   = 1'b1;
            I_SAMPLE:   onehot[SEL_SAMPLE]   = 1'b1;
            I_INTEST:   onehot[SEL_INTEST]   = 1'b1;
            I_RUNBIST:  onehot[SEL_RUNBIST]  = 1'b1;
            I_CLAMP:    onehot[SEL_CLAMP]    = 1'b1;
            I_IDCODE:   onehot[SEL_IDCODE]   = 1'b1;
            I_USERCODE: onehot[SEL_USERCODE] = 1'b1;
            I_HIGHZ:    onehot[SEL_HIGHZ]    = 1'b1;
            default:    onehot[SEL_BYPASS]   = 1'b1;
        endcase
        return onehot;
    endfunction

    always_ff @(posedge TCK) begin
        if (TRST) begin
            state <= S_TLR;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        CAPTUREDR  = 1'b0;
        SHIFTDR    = 1'b0;
        UPDATEDR   = 1'b0;
        TDO_EN     = 1'b0;
        case (state)
            S_TLR:     next_state = TMS ? S_TLR   : S_RTI;
            S_RTI:     next_state = TMS ? S_SELDR : S_RTI;
            S_SELDR:   next_state = TMS ? S_SELIR : S_CAPDR;
            S_CAPDR: begin
                next_state = TMS ? S_EX1DR : S_SHDR;
                CAPTUREDR  = 1'b1;
            end
            S_SHDR: begin
                next_state = TMS ? S_EX1DR : S_SHDR;
                SHIFTDR    = 1'b1;
                TDO_EN     = 1'b1;
            end
            S_EX1DR:   next_state = TMS ? S_UPDDR : S_PAUSEDR;
            S_PAUSEDR: next_state = TMS ? S_EX2DR : S_PAUSEDR;
            S_EX2DR:   next_state = TMS ? S_UPDDR : S_SHDR;
            S_UPDDR: begin
                next_state = TMS ? S_SELDR : S_RTI;
                UPDATEDR   = 1'b1;
            end
            S_SELIR:   next_state = TMS ? S_TLR   : S_CAPIR;
            S_CAPIR:   next_state = TMS ? S_EX1IR : S_SHIR;
            S_SHIR: begin
                next_state = TMS ? S_EX1IR : S_SHIR;
                TDO_EN     = 1'b1;
            end
            S_EX1IR:   next_state = TMS ? S_UPDIR : S_PAUSEIR;
            S_PAUSEIR: next_state = TMS ? S_EX2IR : S_PAUSEIR;
            S_EX2IR:   next_state = TMS ? S_UPDIR : S_SHIR;
            S_UPDIR:   next_state = TMS ? S_SELDR : S_RTI;
            default:   next_state = S_TLR;
        endcase
    end

    // IR capture/shift register; the 01 pattern in the low bits is the 1149.1 capture value.
    always_ff @(posedge TCK) begin
        if (TRST) begin
            ir_sr <= 4'b0001;
        end else if (state == S_CAPIR) begin
            ir_sr <= 4'b0001;
        end else if (state == S_SHIR) begin
            ir_sr <= {TDI, ir_sr[IR_W-1:1]};
        end
    end

    always_ff @(posedge TCK) begin
        if (TRST) begin
            ir_reg <= DEFAULT_IR;
        end else if (next_state == S_TLR) begin
            ir_reg <= DEFAULT_IR;
        end else if (state == S_UPDIR) begin
            ir_reg <= ir_sr;
        end
    end

    // Selects trail IR by one clock; reset loads the default decode directly so one is always high.
    always_ff @(posedge TCK) begin
        if (TRST) begin
            sel <= decode_ir(DEFAULT_IR);
        end else begin
            sel <= decode_ir(ir_reg);
        end
    end

    always_ff @(posedge TCK) begin
        if (TRST) begin
            bypass_bit <= 1'b0;
        end else if (state == S_CAPDR) begin
            bypass_bit <= 1'b0;
        end else if (state == S_SHDR) begin
            bypass_bit <= TDI;
        end
    end

    // Internal serial sources change on rising TCK, so they are relaunched on the falling edge.
    always_ff @(negedge TCK) begin
        tdo_int <= (state == S_SHIR) ? ir_sr[0] : bypass_bit;
    end

    always_comb begin
        TDO = 1'b0;
        if (state == S_SHIR) begin
            TDO = tdo_int;
        end else if (state == S_SHDR) begin
            if (sel[SEL_SAMPLE] || sel[SEL_EXTEST] || sel[SEL_INTEST]) begin
                TDO = BSR_TDO;
            end else if (sel[SEL_IDCODE]) begin
                TDO = ID_REG_TDO;
            end else if (sel[SEL_USERCODE]) begin
                TDO = USER_REG_TDO;
            end else begin
                TDO = tdo_int;
            end
        end
    end

    assign IR              = ir_reg;
    assign TAP_STATE       = state;
    assign BYPASS_SELECT   = sel[SEL_BYPASS];
    assign SAMPLE_SELECT   = sel[SEL_SAMPLE];
    assign EXTEST_SELECT   = sel[SEL_EXTEST];
    assign INTEST_SELECT   = sel[SEL_INTEST];
    assign RUNBIST_SELECT  = sel[SEL_RUNBIST];
    assign CLAMP_SELECT    = sel[SEL_CLAMP];
    assign IDCODE_SELECT   = sel[SEL_IDCODE];
    assign USERCODE_SELECT = sel[SEL_USERCODE];
    assign HIGHZ_SELECT    = sel[SEL_HIGHZ];

endmodule
